// File: rtl/arb_pkg.sv
// Shared types and sizing for the eight-requester priority/round-robin arbiter.
package arb_pkg;
  localparam int N      = 8;
  localparam int IDW    = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/arb_prio_enc.sv
// Combinational 8-to-3 priority encoder; the highest set index wins.
module arb_prio_enc
  import arb_pkg::*;
(
  input  logic [N-1:0]   req,
  output logic [IDW-1:0] id,
  output logic           valid
);

  // Ascending scan so the last (highest) set bit overwrites earlier hits.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        id    = IDW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Bus arbiter: registered one-hot grant with hold limit, fixed or round-robin
// selection built around a single priority encoder.
module priority_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           rr_mode,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [IDW-1:0]    last_id, last_n;
  logic [N-1:0]      gnt_n;
  logic [IDW-1:0]    gnt_id_n;
  logic              gnt_valid_n;

  logic [N-1:0]      owner_mask;
  logic [N-1:0]      arb_req;
  logic [IDW-1:0]    shift;
  logic [2*N-1:0]    rot_dbl;
  logic [N-1:0]      rot_req;
  logic [IDW-1:0]    enc_id;
  logic              enc_valid;
  logic [IDW-1:0]    win_id;
  logic              do_grant;

  // The current owner is excluded from every arbitration taken while BUSY.
  assign owner_mask = (state == BUSY) ? (N'(1) << gnt_id) : '0;
  assign arb_req    = req & ~owner_mask;

  // Rotating by last_id puts index last_id-1 on bit 7, so the encoder's
  // highest-wins rule yields the round-robin search order.
  assign shift   = rr_mode ? last_id : '0;
  assign rot_dbl = {arb_req, arb_req} >> shift;
  assign rot_req = rot_dbl[N-1:0];

  arb_prio_enc u_enc (
    .req   (rot_req),
    .id    (enc_id),
    .valid (enc_valid)
  );

  assign win_id = enc_id + shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last_id   <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      last_id   <= last_n;
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= gnt_valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    hold_n      = hold_cnt;
    last_n      = last_id;
    gnt_n       = gnt;
    gnt_id_n    = gnt_id;
    gnt_valid_n = gnt_valid;
    do_grant    = 1'b0;

    case (state)
      IDLE: do_grant = enc_valid;
      BUSY: begin
        if (!req[gnt_id]) begin
          if (enc_valid) begin
            do_grant = 1'b1;
          end else begin
            state_n     = IDLE;
            hold_n      = '0;
            gnt_n       = '0;
            gnt_id_n    = '0;
            gnt_valid_n = 1'b0;
          end
        end else if (hold_cnt == HOLD_MAX && enc_valid) begin
          do_grant = 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_grant) begin
      state_n     = BUSY;
      hold_n      = '0;
      last_n      = win_id;
      gnt_n       = N'(1) << win_id;
      gnt_id_n    = win_id;
      gnt_valid_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Randomized and directed bench for priority_arbiter against a search-order model.
module tb_priority_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       rr_mode = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  int mOwner = -1;
  int mHold  = 0;
  int mLast  = 0;

  priority_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rr_mode   (rr_mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Walk the candidates in search order; returns -1 when nobody requests.
  function automatic int arbitrate(input logic [7:0] v, input bit rr, input int last);
    int idx;
    for (int k = 1; k <= 8; k++) begin
      idx = rr ? ((last - k + 16) % 8) : (8 - k);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic [7:0] r, input bit rr);
    logic [7:0] masked;
    int w;
    if (mOwner < 0) begin
      w = arbitrate(r, rr, mLast);
      if (w >= 0) begin mOwner = w; mHold = 0; mLast = w; end
    end else begin
      masked = r & ~(8'(1) << mOwner);
      w = arbitrate(masked, rr, mLast);
      if (!r[mOwner]) begin
        if (w >= 0) begin mOwner = w; mHold = 0; mLast = w; end
        else begin mOwner = -1; mHold = 0; end
      end else if (mHold == MAXH - 1 && w >= 0) begin
        mOwner = w; mHold = 0; mLast = w;
      end else if (mHold < MAXH - 1) begin
        mHold++;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_gnt"},   int'(gnt),       (mOwner >= 0) ? (1 << mOwner) : 0);
    checkOutput({tag, "_id"},    int'(gnt_id),    (mOwner >= 0) ? mOwner : 0);
    checkOutput({tag, "_valid"}, int'(gnt_valid), (mOwner >= 0) ? 1 : 0);
  endtask

  task automatic applyStimulus(input logic [7:0] r, input bit rr, input string tag);
    req     = r;
    rr_mode = rr;
    @(posedge clk);
    modelStep(r, rr);
    #1;
    checkModel(tag);
  endtask

  task automatic doAsyncReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_gnt"},   int'(gnt),       0);
    checkOutput({tag, "_id"},    int'(gnt_id),    0);
    checkOutput({tag, "_valid"}, int'(gnt_valid), 0);
    mOwner = -1; mHold = 0; mLast = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gnt",   int'(gnt),       0);
    checkOutput("reset_id",    int'(gnt_id),    0);
    checkOutput("reset_valid", int'(gnt_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, one-cycle latency, then async reset mid-grant.
    applyStimulus(8'h40, 1'b0, "lone");
    checkOutput("lone_first_gnt", int'(gnt), 8'h40);
    checkOutput("lone_first_id",  int'(gnt_id), 6);
    repeat (2) applyStimulus(8'h40, 1'b0, "lone");
    doAsyncReset("async");

    // Fixed priority and zero-gap handoff.
    applyStimulus(8'b10101010, 1'b0, "fixed");
    checkOutput("fixed_hi_id", int'(gnt_id), 7);
    applyStimulus(8'b00011100, 1'b0, "handoff");
    checkOutput("handoff_id", int'(gnt_id), 4);
    doAsyncReset("rst2");

    // Round-robin: each owner drops its request right after being granted.
    r = 8'hFF;
    for (int i = 0; i <= 8; i++) begin
      applyStimulus(r, 1'b1, "rr");
      checkOutput("rr_order", int'(gnt_id), (7 - i) & 7);
      r = 8'hFF & ~gnt;
    end
    doAsyncReset("rst3");

    // Hold limit alternation, then a lone owner is never preempted.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'h81, 1'b0, "hold");
      checkOutput("hold_owner", int'(gnt_id), ((i / MAXH) % 2 == 0) ? 7 : 0);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h80, 1'b0, "alone");
      checkOutput("alone_owner", int'(gnt_id), 7);
    end

    // Release to idle, then a fresh single-cycle grant.
    applyStimulus(8'h00, 1'b0, "drop");
    checkOutput("drop_valid", int'(gnt_valid), 0);
    applyStimulus(8'h00, 1'b0, "idle");
    applyStimulus(8'h01, 1'b0, "regrant");
    checkOutput("regrant_id", int'(gnt_id), 0);
    doAsyncReset("rst4");

    // Mode switch only matters at the next arbitration.
    applyStimulus(8'h08, 1'b1, "mode");
    applyStimulus(8'hFF, 1'b0, "mode");
    checkOutput("mode_keep", int'(gnt_id), 3);
    applyStimulus(8'hF7, 1'b0, "mode");
    checkOutput("mode_next", int'(gnt_id), 7);
    doAsyncReset("rst5");

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'(1) << $urandom_range(0, 7);
        2:       r = 8'($urandom) & 8'($urandom);
        default: r = 8'($urandom);
      endcase
      applyStimulus(r, 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 59) == 0) doAsyncReset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
